// File: rtl/branch_verify_unit.sv
// Branch verification unit: checks resolved EX branches against the fetch-time
// prediction, reports a verify bus to the predictor and redirects fetch after the delay slot.
module branch_verify_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_exc,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic [2:0]       ex_br_type,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             pred_taken,
  input  logic [31:0]      pred_target,
  input  logic [58:0]      pred_entry,
  input  logic             stats_clr,
  output logic             vr_ready,
  output logic [31:0]      vr_pc,
  output logic             vr_is_taken,
  output logic [31:0]      vr_correct_target,
  output logic             vr_predict_success,
  output logic [58:0]      vr_predict_entry,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  typedef enum logic [1:0] {IDLE, WAIT_DS, SQUASH} state_e;

  state_e           state_q, state_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] mispred_count_q, mispred_count_d;

  logic             vr_ready_q;
  logic [31:0]      vr_pc_q;
  logic             vr_is_taken_q;
  logic [31:0]      vr_correct_target_q;
  logic             vr_predict_success_q;
  logic [58:0]      vr_predict_entry_q;

  logic             accept;
  logic             predict_success;
  logic [31:0]      correct_target;
  logic [58:0]      entry_fixed;

  // Branches are only accepted in IDLE, so wrong-path work behind a mispredict is ignored.
  always_comb begin
    accept          = ex_valid && (ex_br_type != 3'd0) && (state_q == IDLE) && !flush_exc;
    correct_target  = ex_taken ? ex_target : (ex_pc + 32'h8);
    predict_success = (pred_taken == ex_taken) && (!ex_taken || (pred_target == ex_target));
    entry_fixed      = pred_entry;
    entry_fixed[4:2] = ex_br_type;
  end

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      IDLE: begin
        if (accept && !predict_success) begin
          state_d       = WAIT_DS;
          redirect_pc_d = correct_target;
        end
      end
      WAIT_DS: begin
        if (ex_valid) state_d = SQUASH;
      end
      SQUASH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_exc) state_d = IDLE;
  end

  // Statistics saturate rather than wrap; a clear beats a same-cycle increment.
  always_comb begin
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (stats_clr) begin
      br_count_d      = '0;
      mispred_count_d = '0;
    end else if (accept) begin
      if (br_count_q != '1) br_count_d = br_count_q + CNT_W'(1);
      if (!predict_success && (mispred_count_q != '1))
        mispred_count_d = mispred_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q              <= IDLE;
      redirect_pc_q        <= '0;
      br_count_q           <= '0;
      mispred_count_q      <= '0;
      vr_ready_q           <= 1'b0;
      vr_pc_q              <= '0;
      vr_is_taken_q        <= 1'b0;
      vr_correct_target_q  <= '0;
      vr_predict_success_q <= 1'b0;
      vr_predict_entry_q   <= '0;
    end else begin
      state_q         <= state_d;
      redirect_pc_q   <= redirect_pc_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
      vr_ready_q      <= accept;
      if (accept) begin
        vr_pc_q              <= ex_pc;
        vr_is_taken_q        <= ex_taken;
        vr_correct_target_q  <= correct_target;
        vr_predict_success_q <= predict_success;
        vr_predict_entry_q   <= entry_fixed;
      end
    end
  end

  assign vr_ready           = vr_ready_q;
  assign vr_pc              = vr_pc_q;
  assign vr_is_taken        = vr_is_taken_q;
  assign vr_correct_target  = vr_correct_target_q;
  assign vr_predict_success = vr_predict_success_q;
  assign vr_predict_entry   = vr_predict_entry_q;
  assign redirect_valid     = (state_q == SQUASH);
  assign redirect_pc        = redirect_pc_q;
  assign br_count           = br_count_q;
  assign mispred_count      = mispred_count_q;

endmodule

// File: tb/tb_branch_verify_unit.sv
// Testbench for branch_verify_unit: directed vector table, hand-written corner sequences
// and randomized traffic compared against a behavioural model of the verify/redirect rules.
module tb_branch_verify_unit;

   localparam int CW = 4;
   localparam logic [58:0] BASE_ENTRY = {22'h155555, 32'hCAFEF00D, 3'b000, 2'b01};

   logic          clk = 1'b0;
   logic          reset, flushExc, exValid, exTaken, predTaken, statsClr;
   logic [31:0]   exPc, exTarget, predTarget;
   logic [2:0]    exBrType;
   logic [58:0]   predEntry;

   logic          vrReady, vrIsTaken, vrPredictSuccess, redirectValid;
   logic [31:0]   vrPc, vrCorrectTarget, redirectPc;
   logic [58:0]   vrPredictEntry;
   logic [CW-1:0] brCount, mispredCount;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] pc;
      logic [2:0]  brType;
      logic        taken;
      logic [31:0] target;
      logic        predTaken;
      logic [31:0] predTarget;
      logic [31:0] expCorrect;
      logic        expSuccess;
   } vector_t;

   vector_t vectors[7];

   // Behavioural reference state for the randomized phase
   logic          mPending, mSquash, mVrReady, mVrTaken, mVrSuccess;
   logic [31:0]   mVrPc, mVrCorrect, mRedirPc;
   logic [58:0]   mVrEntry;
   logic [CW-1:0] mBr, mMis;

   branch_verify_unit #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .flush_exc(flushExc), .ex_valid(exValid),
      .ex_pc(exPc), .ex_br_type(exBrType), .ex_taken(exTaken), .ex_target(exTarget),
      .pred_taken(predTaken), .pred_target(predTarget), .pred_entry(predEntry),
      .stats_clr(statsClr),
      .vr_ready(vrReady), .vr_pc(vrPc), .vr_is_taken(vrIsTaken),
      .vr_correct_target(vrCorrectTarget), .vr_predict_success(vrPredictSuccess),
      .vr_predict_entry(vrPredictEntry), .redirect_valid(redirectValid),
      .redirect_pc(redirectPc), .br_count(brCount), .mispred_count(mispredCount)
   );

   always #5 clk = ~clk;

   // Advance one clock and settle just after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
      end
   endtask

   task automatic idleInputs();
      flushExc   = 1'b0;
      statsClr   = 1'b0;
      exValid    = 1'b0;
      exBrType   = 3'd0;
      exPc       = 32'h0;
      exTaken    = 1'b0;
      exTarget   = 32'h0;
      predTaken  = 1'b0;
      predTarget = 32'h0;
      predEntry  = BASE_ENTRY;
   endtask

   task automatic applyStimulus(input vector_t v);
      exValid    = 1'b1;
      exBrType   = v.brType;
      exPc       = v.pc;
      exTaken    = v.taken;
      exTarget   = v.target;
      predTaken  = v.predTaken;
      predTarget = v.predTarget;
      predEntry  = BASE_ENTRY;
   endtask

   task automatic delaySlot();
      idleInputs();
      exValid = 1'b1;
   endtask

   task automatic clearStats();
      idleInputs();
      statsClr = 1'b1;
      step();
      idleInputs();
   endtask

   // Behavioural model: one call per clock edge, using the stimulus held for that cycle
   task automatic modelEdge();
      logic        accept, success;
      logic [31:0] target;
      if (reset) begin
         mPending = 0; mSquash = 0; mVrReady = 0; mBr = '0; mMis = '0; mRedirPc = '0;
      end else begin
         accept  = exValid && (exBrType != 0) && !mPending && !flushExc;
         target  = exTaken ? exTarget : exPc + 32'd8;
         success = (predTaken == exTaken) && (!exTaken || predTarget == exTarget);
         mVrReady = accept;
         if (accept) begin
            mVrPc      = exPc;
            mVrTaken   = exTaken;
            mVrCorrect = target;
            mVrSuccess = success;
            mVrEntry   = (predEntry & ~(59'd7 << 2)) | (59'(exBrType) << 2);
         end
         if (statsClr) begin
            mBr = '0; mMis = '0;
         end else if (accept) begin
            if (int'(mBr) < (1 << CW) - 1) mBr = mBr + 1'b1;
            if (!success && int'(mMis) < (1 << CW) - 1) mMis = mMis + 1'b1;
         end
         if (flushExc) begin
            mPending = 0; mSquash = 0;
         end else if (mSquash) begin
            mPending = 0; mSquash = 0;
         end else if (mPending) begin
            if (exValid) mSquash = 1;
         end else if (accept && !success) begin
            mPending = 1;
            mRedirPc = target;
         end
      end
   endtask

   task automatic compareModel();
      checkOutput("rnd vr_ready", vrReady, mVrReady);
      checkOutput("rnd redirect_valid", redirectValid, mSquash);
      checkOutput("rnd br_count", brCount, mBr);
      checkOutput("rnd mispred_count", mispredCount, mMis);
      if (mVrReady) begin
         checkOutput("rnd vr_pc", vrPc, mVrPc);
         checkOutput("rnd vr_is_taken", vrIsTaken, mVrTaken);
         checkOutput("rnd vr_correct_target", vrCorrectTarget, mVrCorrect);
         checkOutput("rnd vr_predict_success", vrPredictSuccess, mVrSuccess);
         checkOutput("rnd vr_predict_entry", vrPredictEntry, mVrEntry);
      end
      if (mSquash) checkOutput("rnd redirect_pc", redirectPc, mRedirPc);
   endtask

   initial begin
      int expBr, expMis;

      vectors[0] = '{32'h80001000, 3'd1, 1'b1, 32'h80001040, 1'b1, 32'h80001040, 32'h80001040, 1'b1};
      vectors[1] = '{32'h80001000, 3'd1, 1'b0, 32'h80001040, 1'b1, 32'h80001040, 32'h80001008, 1'b0};
      vectors[2] = '{32'h80002F00, 3'd4, 1'b1, 32'h80002000, 1'b1, 32'h80003000, 32'h80002000, 1'b0};
      vectors[3] = '{32'h00000100, 3'd1, 1'b0, 32'h00000200, 1'b0, 32'h00000300, 32'h00000108, 1'b1};
      vectors[4] = '{32'h00000400, 3'd2, 1'b1, 32'h00000800, 1'b0, 32'h00000800, 32'h00000800, 1'b0};
      vectors[5] = '{32'hFFFFFFFC, 3'd1, 1'b0, 32'h00000010, 1'b0, 32'h00000000, 32'h00000004, 1'b1};
      vectors[6] = '{32'h00001000, 3'd3, 1'b1, 32'h00005000, 1'b1, 32'h00005000, 32'h00005000, 1'b1};

      idleInputs();
      reset = 1'b1;
      step();
      step();
      checkOutput("reset vr_ready", vrReady, 0);
      checkOutput("reset vr_pc", vrPc, 0);
      checkOutput("reset vr_is_taken", vrIsTaken, 0);
      checkOutput("reset vr_correct_target", vrCorrectTarget, 0);
      checkOutput("reset vr_predict_success", vrPredictSuccess, 0);
      checkOutput("reset vr_predict_entry", vrPredictEntry, 0);
      checkOutput("reset redirect_valid", redirectValid, 0);
      checkOutput("reset redirect_pc", redirectPc, 0);
      checkOutput("reset br_count", brCount, 0);
      checkOutput("reset mispred_count", mispredCount, 0);
      reset = 1'b0;

      // Directed vector table, each applied from IDLE
      expBr = 0;
      expMis = 0;
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vectors[i]);
         step();
         idleInputs();
         expBr++;
         if (!vectors[i].expSuccess) expMis++;
         checkOutput($sformatf("vec%0d vr_ready", i), vrReady, 1);
         checkOutput($sformatf("vec%0d vr_pc", i), vrPc, vectors[i].pc);
         checkOutput($sformatf("vec%0d vr_is_taken", i), vrIsTaken, vectors[i].taken);
         checkOutput($sformatf("vec%0d vr_correct_target", i), vrCorrectTarget, vectors[i].expCorrect);
         checkOutput($sformatf("vec%0d vr_predict_success", i), vrPredictSuccess, vectors[i].expSuccess);
         checkOutput($sformatf("vec%0d vr_predict_entry", i), vrPredictEntry,
                     BASE_ENTRY | (59'(vectors[i].brType) << 2));
         checkOutput($sformatf("vec%0d br_count", i), brCount, expBr);
         checkOutput($sformatf("vec%0d mispred_count", i), mispredCount, expMis);
         checkOutput($sformatf("vec%0d redirect_valid early", i), redirectValid, 0);
         step();
         checkOutput($sformatf("vec%0d vr_ready pulse", i), vrReady, 0);
         checkOutput($sformatf("vec%0d redirect_valid gap", i), redirectValid, 0);
         if (!vectors[i].expSuccess) begin
            delaySlot();
            step();
            idleInputs();
            checkOutput($sformatf("vec%0d redirect_valid", i), redirectValid, 1);
            checkOutput($sformatf("vec%0d redirect_pc", i), redirectPc, vectors[i].expCorrect);
            checkOutput($sformatf("vec%0d vr_ready slot", i), vrReady, 0);
            step();
            checkOutput($sformatf("vec%0d redirect_valid end", i), redirectValid, 0);
         end
      end

      // Wrong-path branch during SQUASH
      clearStats();
      applyStimulus(vectors[1]);
      step();
      delaySlot();
      step();
      checkOutput("wrongpath redirect_valid", redirectValid, 1);
      applyStimulus(vectors[0]);
      step();
      idleInputs();
      checkOutput("wrongpath vr_ready", vrReady, 0);
      checkOutput("wrongpath br_count", brCount, 1);
      checkOutput("wrongpath redirect_valid after", redirectValid, 0);
      step();

      // Exception flush while waiting for the delay slot
      clearStats();
      applyStimulus(vectors[2]);
      step();
      delaySlot();
      flushExc = 1'b1;
      step();
      idleInputs();
      checkOutput("flushds redirect_valid", redirectValid, 0);
      checkOutput("flushds vr_ready", vrReady, 0);
      applyStimulus(vectors[0]);
      step();
      idleInputs();
      checkOutput("flushds idle accept", vrReady, 1);
      checkOutput("flushds redirect_valid later", redirectValid, 0);
      checkOutput("flushds br_count", brCount, 2);
      checkOutput("flushds mispred_count", mispredCount, 1);
      step();
      checkOutput("flushds redirect_valid end", redirectValid, 0);

      // Exception flush coincident with a mispredicted branch
      clearStats();
      applyStimulus(vectors[1]);
      flushExc = 1'b1;
      step();
      delaySlot();
      checkOutput("flushbr vr_ready", vrReady, 0);
      checkOutput("flushbr br_count", brCount, 0);
      checkOutput("flushbr mispred_count", mispredCount, 0);
      step();
      idleInputs();
      checkOutput("flushbr redirect_valid", redirectValid, 0);

      // Reset in the middle of WAIT_DS
      applyStimulus(vectors[1]);
      step();
      delaySlot();
      reset = 1'b1;
      step();
      reset = 1'b0;
      idleInputs();
      checkOutput("rstds redirect_valid", redirectValid, 0);
      checkOutput("rstds vr_ready", vrReady, 0);
      checkOutput("rstds br_count", brCount, 0);
      checkOutput("rstds redirect_pc", redirectPc, 0);
      step();
      checkOutput("rstds redirect_valid later", redirectValid, 0);

      // Reset in the middle of SQUASH
      applyStimulus(vectors[2]);
      step();
      delaySlot();
      step();
      idleInputs();
      checkOutput("rstsq redirect_valid before", redirectValid, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      checkOutput("rstsq redirect_valid", redirectValid, 0);
      step();
      checkOutput("rstsq redirect_valid later", redirectValid, 0);

      // Counter saturation and clear priority
      clearStats();
      for (int i = 0; i < 17; i++) begin
         applyStimulus(vectors[0]);
         step();
      end
      idleInputs();
      checkOutput("sat br_count", brCount, 4'hF);
      checkOutput("sat mispred_count", mispredCount, 0);
      for (int i = 0; i < 17; i++) begin
         applyStimulus(vectors[4]);
         step();
         delaySlot();
         step();
         idleInputs();
         step();
      end
      checkOutput("sat mispred_count full", mispredCount, 4'hF);
      checkOutput("sat br_count held", brCount, 4'hF);
      applyStimulus(vectors[1]);
      statsClr = 1'b1;
      step();
      idleInputs();
      checkOutput("clrpri br_count", brCount, 0);
      checkOutput("clrpri mispred_count", mispredCount, 0);
      step();
      delaySlot();
      step();
      idleInputs();
      step();

      // Randomized traffic against the behavioural model
      reset = 1'b1;
      modelEdge();
      step();
      reset = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         reset      = ($urandom_range(0, 199) == 0);
         flushExc   = ($urandom_range(0, 19) == 0);
         statsClr   = ($urandom_range(0, 49) == 0);
         exValid    = ($urandom_range(0, 9) < 7);
         exBrType   = 3'($urandom_range(0, 4));
         exPc       = $urandom & 32'hFFFFFFFC;
         exTaken    = 1'($urandom_range(0, 1));
         exTarget   = $urandom & 32'hFFFFFFFC;
         predTaken  = ($urandom_range(0, 3) == 0) ? ~exTaken : exTaken;
         predTarget = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFFFFFC) : exTarget;
         predEntry  = 59'({$urandom, $urandom});
         modelEdge();
         step();
         compareModel();
      end
      reset = 1'b0;
      idleInputs();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
